lcd_char_sequencer: RTL

//  Upstream feeder for lcd_12864. Buffers character-write commands (x, y, glyph index, show) from
//  the light-pen/app logic in a FIFO. Issues them one at a time on the lcd_12864 pos/char inputs,

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_cmd_fifo.sv | 59 +++++
 rtl/lcd_char_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and screen geometry for the lcd_12864 character feeder.
// A command is one cell write: position, glyph index and draw/blank flag.
package lcd_pkg;
    localparam int SCREEN_COLS = 16;
    localparam int SCREEN_ROWS = 16;
    localparam int POS_W       = 4;
    localparam int IDX_W       = 4;

    localparam logic [POS_W-1:0] LAST_COL = POS_W'(SCREEN_COLS - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(SCREEN_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_CLR_NEXT
    } seq_state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [IDX_W-1:0] glyph;
        logic             show;
    } lcd_cmd_t;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO. The head is read combinationally so the
// sequencer can pop and latch a command in the same cycle it sees it.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  lcd_cmd_t                 push_data,
    input  logic                     pop,
    output lcd_cmd_t                 head,
    output logic                     empty,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    lcd_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             ready_reg;

    always_comb begin
        level_next = level_reg;
        unique case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
            ready_reg <= (level_next != LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign empty = (level_reg == '0);
    assign ready = ready_reg;
    assign level = level_reg;
endmodule

// File: rtl/lcd_char_sequencer.sv
// Feeds buffered cell writes to lcd_12864 one at a time, paced by lcd_ok,
// and runs full-screen blank sweeps ahead of any queued commands.
module lcd_char_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [POS_W-1:0]              cmd_x_i,
    input  logic [POS_W-1:0]              cmd_y_i,
    input  logic [IDX_W-1:0]              cmd_char_i,
    input  logic                          cmd_show_i,
    input  logic                          clear_req_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          timeout_o,
    input  logic                          lcd_ok_i,
    output logic [POS_W-1:0]              pos_x_o,
    output logic [POS_W-1:0]              pos_y_o,
    output logic [IDX_W-1:0]              char_index_o,
    output logic                          char_show_o
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);

    seq_state_t        state_reg, state_next;
    lcd_cmd_t          out_reg, out_next, fifo_head, cmd_in;
    logic [POS_W-1:0]  clr_x_reg, clr_x_next, clr_y_reg, clr_y_next;
    logic              sweep_reg, sweep_next, pending_reg, pending_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic              timeout_reg, timeout_next, busy_reg, busy_next;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_ready;
    logic [LVL_W-1:0]  fifo_level, fifo_level_next;

    assign cmd_in    = '{x: cmd_x_i, y: cmd_y_i, glyph: cmd_char_i, show: cmd_show_i};
    assign fifo_push = cmd_valid_i & fifo_ready;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk_i),
        .rst_n      (reset_n_i),
        .push       (fifo_push),
        .push_data  (cmd_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .ready      (fifo_ready),
        .level      (fifo_level),
        .level_next (fifo_level_next)
    );

    always_comb begin
        state_next   = state_reg;
        out_next     = out_reg;
        clr_x_next   = clr_x_reg;
        clr_y_next   = clr_y_reg;
        sweep_next   = sweep_reg;
        pending_next = pending_reg;
        tcnt_next    = tcnt_reg;
        timeout_next = timeout_reg;
        fifo_pop     = 1'b0;
        // A pending clear stays set for the whole sweep, so repeat pulses fold into it.
        if (clear_req_i && !pending_reg) pending_next = 1'b1;
        unique case (state_reg)
            S_IDLE: begin
                if (pending_reg) begin
                    clr_x_next = '0;
                    clr_y_next = '0;
                    sweep_next = 1'b1;
                    out_next   = '0;
                    state_next = S_ISSUE;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    out_next   = fifo_head;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tcnt_next  = '0;
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!lcd_ok_i) begin
                    state_next = S_WAIT_DONE;
                end else if (tcnt_reg == TCNT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = sweep_reg ? S_CLR_NEXT : S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (lcd_ok_i) state_next = sweep_reg ? S_CLR_NEXT : S_IDLE;
            end
            S_CLR_NEXT: begin
                if (clr_x_reg == LAST_COL && clr_y_reg == LAST_ROW) begin
                    pending_next = 1'b0;
                    sweep_next   = 1'b0;
                    state_next   = S_IDLE;
                end else begin
                    if (clr_x_reg == LAST_COL) begin
                        clr_x_next = '0;
                        clr_y_next = clr_y_reg + 1'b1;
                    end else begin
                        clr_x_next = clr_x_reg + 1'b1;
                    end
                    out_next   = '{x: clr_x_next, y: clr_y_next, glyph: '0, show: 1'b0};
                    state_next = S_ISSUE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next != S_IDLE) || (fifo_level_next != '0) || pending_next;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg   <= S_IDLE;
            out_reg     <= '0;
            clr_x_reg   <= '0;
            clr_y_reg   <= '0;
            sweep_reg   <= 1'b0;
            pending_reg <= 1'b0;
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            out_reg     <= out_next;
            clr_x_reg   <= clr_x_next;
            clr_y_reg   <= clr_y_next;
            sweep_reg   <= sweep_next;
            pending_reg <= pending_next;
            tcnt_reg    <= tcnt_next;
            timeout_reg <= timeout_next;
            busy_reg    <= busy_next;
        end
    end

    assign cmd_ready_o  = fifo_ready;
    assign fifo_level_o = fifo_level;
    assign busy_o       = busy_reg;
    assign timeout_o    = timeout_reg;
    assign pos_x_o      = out_reg.x;
    assign pos_y_o      = out_reg.y;
    assign char_index_o = out_reg.glyph;
    assign char_show_o  = out_reg.show;
endmodule
